// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: D-stage decode inputs and staged E/M/W control outputs
interface pipelined_control_unit_if #(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3
);
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  valid_d;
    logic                  stall_e;
    logic                  flush_e;
    logic [IMM_SRC_W-1:0]  imm_src_d;
    logic                  illegal_d;
    logic [ALU_CTRL_W-1:0] alu_ctrl_e;
    logic                  alu_src_e;
    logic                  alu_a_pc_e;
    logic                  branch_e;
    logic [2:0]            br_funct3_e;
    logic                  jump_e;
    logic                  jalr_e;
    logic                  illegal_e;
    logic                  reg_write_e;
    logic                  result_src_e0;
    logic                  mem_write_m;
    logic [2:0]            mem_size_m;
    logic                  reg_write_m;
    logic                  reg_write_w;
    logic [1:0]            result_src_w;
    modport master (
        output op, funct3, funct7b5, valid_d, stall_e, flush_e,
        input  imm_src_d, illegal_d, alu_ctrl_e, alu_src_e, alu_a_pc_e, branch_e, br_funct3_e,
               jump_e, jalr_e, illegal_e, reg_write_e, result_src_e0, mem_write_m, mem_size_m,
               reg_write_m, reg_write_w, result_src_w
    );
    modport slave (
        input  op, funct3, funct7b5, valid_d, stall_e, flush_e,
        output imm_src_d, illegal_d, alu_ctrl_e, alu_src_e, alu_a_pc_e, branch_e, br_funct3_e,
               jump_e, jalr_e, illegal_e, reg_write_e, result_src_e0, mem_write_m, mem_size_m,
               reg_write_m, reg_write_w, result_src_w
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I decode in D, control carried through E/M/W with stall/flush
module pipelined_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3,
    parameter bit EN_UPPER   = 1'b1,
    parameter bit EN_JALR    = 1'b1
) (
    input logic clk,
    input logic rst_n,
    pipelined_control_unit_if.slave bus
);
    typedef logic [ALU_CTRL_W-1:0] alu_t;
    localparam alu_t ALU_ADD = alu_t'(0),  ALU_SUB  = alu_t'(1), ALU_AND = alu_t'(2);
    localparam alu_t ALU_OR  = alu_t'(3),  ALU_XOR  = alu_t'(4), ALU_SLT = alu_t'(5);
    localparam alu_t ALU_SLTU = alu_t'(6), ALU_SLL  = alu_t'(7), ALU_SRL = alu_t'(8);
    localparam alu_t ALU_SRA = alu_t'(9),  ALU_PASSB = alu_t'(10);
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic       alu_a_pc;
        alu_t       alu_ctrl;
        logic [2:0] f3;
        logic       illegal;
    } ctrl_e_t;
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [2:0] size;
        logic [1:0] result_src;
    } ctrl_m_t;
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;
    ctrl_e_t dec, e_d, e_q;
    ctrl_m_t m_d, m_q;
    ctrl_w_t w_d, w_q;
    logic [IMM_SRC_W-1:0] imm_src;
    logic known;
    // alt selects the funct7b5 variant (SUB for f3=000, SRA for f3=101)
    function automatic alu_t alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction
    always_comb begin
        dec     = '0;
        imm_src = '0;
        known   = 1'b1;
        case (bus.op)
            7'b0000011: begin dec.reg_write = 1'b1; dec.result_src = 2'b01; dec.alu_src = 1'b1; end
            7'b0100011: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; imm_src = IMM_SRC_W'(1); end
            7'b0110011: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_dec(bus.funct3, bus.funct7b5);
                known = !bus.funct7b5 || bus.funct3 == 3'b000 || bus.funct3 == 3'b101;
            end
            // for non-shift I-ALU ops instr[30] is an immediate bit and is ignored
            7'b0010011: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_dec(bus.funct3, bus.funct7b5 && bus.funct3 == 3'b101);
                known = !(bus.funct7b5 && bus.funct3 == 3'b001);
            end
            7'b1100011: begin dec.branch = 1'b1; dec.alu_ctrl = ALU_SUB; imm_src = IMM_SRC_W'(2); end
            7'b1101111: begin
                dec.jump = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'b10; imm_src = IMM_SRC_W'(3);
            end
            7'b1100111: begin
                dec.jump = 1'b1; dec.jalr = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'b10;
                dec.alu_src = 1'b1;
                known = EN_JALR && bus.funct3 == 3'b000;
            end
            7'b0110111: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = ALU_PASSB;
                imm_src = IMM_SRC_W'(4); known = EN_UPPER;
            end
            7'b0010111: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_a_pc = 1'b1;
                imm_src = IMM_SRC_W'(4); known = EN_UPPER;
            end
            default: known = 1'b0;
        endcase
        dec.f3 = bus.funct3;
        if (!bus.valid_d || !known) begin
            dec     = '0;
            imm_src = '0;
        end
        dec.illegal = bus.valid_d && !known;
    end
    always_comb begin
        e_d = bus.flush_e ? '0 : bus.stall_e ? e_q : dec;
        m_d = bus.stall_e ? '0 : '{reg_write: e_q.reg_write, mem_write: e_q.mem_write,
                                   size: e_q.f3, result_src: e_q.result_src};
        w_d = '{reg_write: m_q.reg_write, result_src: m_q.result_src};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end
    assign bus.imm_src_d     = imm_src;
    assign bus.illegal_d     = dec.illegal;
    assign bus.alu_ctrl_e    = e_q.alu_ctrl;
    assign bus.alu_src_e     = e_q.alu_src;
    assign bus.alu_a_pc_e    = e_q.alu_a_pc;
    assign bus.branch_e      = e_q.branch;
    assign bus.br_funct3_e   = e_q.f3;
    assign bus.jump_e        = e_q.jump;
    assign bus.jalr_e        = e_q.jalr;
    assign bus.illegal_e     = e_q.illegal;
    assign bus.reg_write_e   = e_q.reg_write;
    assign bus.result_src_e0 = e_q.result_src[0];
    assign bus.mem_write_m   = m_q.mem_write;
    assign bus.mem_size_m    = m_q.size;
    assign bus.reg_write_m   = m_q.reg_write;
    assign bus.reg_write_w   = w_q.reg_write;
    assign bus.result_src_w  = w_q.result_src;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed + random checks of two builds (EN_UPPER=1/0) against a decode/pipeline model
module tb_pipelined_control_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    pipelined_control_unit_if b0 ();
    pipelined_control_unit_if b1 ();
    assign b1.op = b0.op;
    assign b1.funct3 = b0.funct3;
    assign b1.funct7b5 = b0.funct7b5;
    assign b1.valid_d = b0.valid_d;
    assign b1.stall_e = b0.stall_e;
    assign b1.flush_e = b0.flush_e;
    pipelined_control_unit #(.EN_UPPER(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    pipelined_control_unit #(.EN_UPPER(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    typedef enum {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_ILL} kind_t;
    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw, br, jmp, jalr, src, apc;
        logic [3:0] alu;
        logic [2:0] f3, imm;
        logic       ill;
    } dec_t;
    dec_t me[2], mm[2], mw[2];
    int total = 0, passed = 0, fails = 0;

    logic [3:0]  od[2];
    logic [14:0] oe[2];
    logic [4:0]  om[2];
    logic [2:0]  ow[2];
    assign od[0] = {b0.imm_src_d, b0.illegal_d};
    assign od[1] = {b1.imm_src_d, b1.illegal_d};
    assign oe[0] = {b0.alu_ctrl_e, b0.alu_src_e, b0.alu_a_pc_e, b0.branch_e, b0.br_funct3_e,
                    b0.jump_e, b0.jalr_e, b0.illegal_e, b0.reg_write_e, b0.result_src_e0};
    assign oe[1] = {b1.alu_ctrl_e, b1.alu_src_e, b1.alu_a_pc_e, b1.branch_e, b1.br_funct3_e,
                    b1.jump_e, b1.jalr_e, b1.illegal_e, b1.reg_write_e, b1.result_src_e0};
    assign om[0] = {b0.mem_write_m, b0.mem_size_m, b0.reg_write_m};
    assign om[1] = {b1.mem_write_m, b1.mem_size_m, b1.reg_write_m};
    assign ow[0] = {b0.reg_write_w, b0.result_src_w};
    assign ow[1] = {b1.reg_write_w, b1.result_src_w};

    function automatic kind_t classify(logic [6:0] op, logic [2:0] f3, logic f7, bit up);
        case (op)
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b0110011: return (f7 && f3 != 3'd0 && f3 != 3'd5) ? K_ILL : K_R;
            7'b0010011: return (f7 && f3 == 3'd1) ? K_ILL : K_I;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return f3 == 3'd0 ? K_JALR : K_ILL;
            7'b0110111: return up ? K_LUI : K_ILL;
            7'b0010111: return up ? K_AUIPC : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic dec_t model(logic [6:0] op, logic [2:0] f3, logic f7, logic v, bit up);
        kind_t k = classify(op, f3, f7, up);
        logic [3:0] tab[8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        dec_t d = '0;
        if (!v) return d;
        if (k == K_ILL) begin
            d.ill = 1'b1;
            return d;
        end
        d.rw   = k inside {K_LOAD, K_R, K_I, K_JAL, K_JALR, K_LUI, K_AUIPC};
        d.rs   = k == K_LOAD ? 2'd1 : (k inside {K_JAL, K_JALR}) ? 2'd2 : 2'd0;
        d.mw   = k == K_STORE;
        d.br   = k == K_BR;
        d.jmp  = k inside {K_JAL, K_JALR};
        d.jalr = k == K_JALR;
        d.src  = k inside {K_LOAD, K_STORE, K_I, K_JALR, K_LUI, K_AUIPC};
        d.apc  = k == K_AUIPC;
        d.imm  = k == K_STORE ? 3'd1 : k == K_BR ? 3'd2 : k == K_JAL ? 3'd3 :
                 (k inside {K_LUI, K_AUIPC}) ? 3'd4 : 3'd0;
        if (k inside {K_R, K_I})
            d.alu = (f3 == 3'd5 && f7) ? 4'd9 : (k == K_R && f3 == 3'd0 && f7) ? 4'd1 : tab[f3];
        else
            d.alu = k == K_LUI ? 4'd10 : k == K_BR ? 4'd1 : 4'd0;
        d.f3 = f3;
        return d;
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_stages();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("E%0d", i), 32'(oe[i]), 32'({me[i].alu, me[i].src, me[i].apc, me[i].br,
                me[i].f3, me[i].jmp, me[i].jalr, me[i].ill, me[i].rw, me[i].rs[0]}));
            chk($sformatf("M%0d", i), 32'(om[i]), 32'({mm[i].mw, mm[i].f3, mm[i].rw}));
            chk($sformatf("W%0d", i), 32'(ow[i]), 32'({mw[i].rw, mw[i].rs}));
        end
    endtask

    task automatic step(logic [6:0] op, logic [2:0] f3, logic f7, logic v, logic st, logic fl);
        dec_t d;
        b0.op = op; b0.funct3 = f3; b0.funct7b5 = f7; b0.valid_d = v; b0.stall_e = st; b0.flush_e = fl;
        #1;
        for (int i = 0; i < 2; i++) begin
            d = model(op, f3, f7, v, i == 0);
            chk($sformatf("D%0d op=%0h", i, op), 32'(od[i]), 32'({d.imm, d.ill}));
            mw[i] = mm[i];
            mm[i] = st ? '0 : me[i];
            me[i] = fl ? '0 : st ? me[i] : d;
        end
        @(posedge clk);
        @(negedge clk);
        chk_stages();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            me[i] = '0; mm[i] = '0; mw[i] = '0;
        end
        chk_stages();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_stages();
    endtask

    logic [6:0] ops[9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

    initial begin
        b0.op = '0; b0.funct3 = '0; b0.funct7b5 = 1'b0; b0.valid_d = 1'b0; b0.stall_e = 1'b0; b0.flush_e = 1'b0;
        for (int i = 0; i < 2; i++) begin
            me[i] = '0; mm[i] = '0; mw[i] = '0;
        end
        @(posedge clk);
        @(negedge clk);
        chk_stages();
        rst_n = 1'b1;
        // add then sub
        step(7'h33, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0); chk("add_alu_e", 32'(b0.alu_ctrl_e), 0);
        step(7'h33, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0); chk("sub_alu_e", 32'(b0.alu_ctrl_e), 1);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("add_w", 32'({b0.reg_write_w, b0.result_src_w}), 3'b100);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("sub_w", 32'({b0.reg_write_w, b0.result_src_w}), 3'b100);
        // lw
        step(7'h03, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0); chk("lw_e0", 32'(b0.result_src_e0), 1);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("lw_size_m", 32'(b0.mem_size_m), 3'b010);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("lw_w", 32'(b0.result_src_w), 2'b01);
        // jalr legal then bad funct3
        step(7'h67, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("jalr_e", 32'({b0.jump_e, b0.jalr_e, b0.alu_ctrl_e}), 6'b110000);
        step(7'h67, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0); chk("jalr_bad_e", 32'({b0.illegal_e, b0.reg_write_e}), 2'b10);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("jalr_w", 32'(b0.result_src_w), 2'b10);
        // store held by two stall cycles
        step(7'h23, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0); chk("sw_stall1_m", 32'(b0.mem_write_m), 0);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0); chk("sw_stall2_m", 32'(b0.mem_write_m), 0);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("sw_go_m", 32'(b0.mem_write_m), 1);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("sw_once_m", 32'(b0.mem_write_m), 0);
        // mid-stream reset, then one quiet cycle after release
        step(7'h33, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(7'h03, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // beq, then beq with flush and stall together
        step(7'h63, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0); chk("beq_e", 32'(b0.branch_e), 1);
        step(7'h63, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1); chk("beq_flush_e", 32'(b0.branch_e), 0);
        // lui: illegal in the EN_UPPER=0 build
        step(7'h37, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0); chk("lui_off_e", 32'({b1.illegal_e, b1.reg_write_e}), 2'b10);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("lui_off_m", 32'(b1.reg_write_m), 0);
        step(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("lui_off_w", 32'(b1.reg_write_w), 0);
        chk("lui_on_w", 32'(b0.reg_write_w), 1);
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            else step($urandom_range(0, 4) == 0 ? 7'($urandom) : ops[$urandom_range(0, 8)],
                      3'($urandom), 1'($urandom), $urandom_range(0, 9) != 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
